// File: rtl/aes_ters_tur_cekirdegi_pkg.sv
`default_nettype none
// aes_paket: FSM encodings, round count and GF(2^8) helpers shared by the AES inverse-cipher core. rev 1.0
package aes_paket;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    TUR   = 2'd1,
    SON   = 2'd2,
    CIKIS = 2'd3
  } durum_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_carp_09(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_carp_0b(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_carp_0d(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_carp_0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Shift-and-add product; used only to build the field inverse for the S-box.
  function automatic logic [7:0] gf_carp(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_ters(input logic [7:0] x);
    logic [7:0] p, acc;
    p   = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_carp(p, p);
      acc = gf_carp(acc, p);
    end
    return acc;
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4. Row r rotates right by r.
  function automatic logic [127:0] ters_satir_kaydir(input logic [127:0] d);
    logic [127:0] o;
    int kaynak;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      kaynak = 4 * (((k / 4) - (k % 4) + 4) % 4) + (k % 4);
      o[127-8*k -: 8] = d[127-8*kaynak -: 8];
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_ters_tur_cekirdegi_ters_sbox.sv
`default_nettype none
// ters_sbox: combinational AES inverse S-box (inverse affine map, then field inverse). rev 1.0
module ters_sbox
  import aes_paket::*;
(
  input  logic [7:0] giris_i,
  output logic [7:0] cikis_o
);

  logic [7:0] afin_ters;

  assign afin_ters = {giris_i[6:0], giris_i[7]}
                   ^ {giris_i[4:0], giris_i[7:5]}
                   ^ {giris_i[1:0], giris_i[7:2]}
                   ^ 8'h05;

  assign cikis_o = gf_ters(afin_ters);

endmodule
`default_nettype wire

// File: rtl/aes_ters_tur_cekirdegi.sv
`default_nettype none
// aes_ters_tur_cekirdegi: iterative AES-128 decryption, one inverse round per clock. rev 1.0
// Optional block counter output blok_sayisi enabled with `define AES_BLOK_SAYACI_EN.
module aes_ters_tur_cekirdegi
  import aes_paket::*;
#(
  parameter int NR       = AES_NR,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                giris_gecerli,
  output logic                giris_hazir,
  input  logic [127:0]        sifreli_matris,
  output logic [RK_IDX_W-1:0] anahtar_idx,
  input  logic [127:0]        tur_anahtari,
  output logic                cikis_gecerli,
  input  logic                cikis_hazir,
  output logic [127:0]        cozulmus_matris
`ifdef AES_BLOK_SAYACI_EN
  ,
  output logic [31:0]         blok_sayisi
`endif
);

  localparam int SAYAC_W = $clog2(NR + 1);

  durum_e               state_q;
  logic [127:0]         durum_q;
  logic [SAYAC_W-1:0]   sayac_q;
  logic                 giris_hazir_q;
  logic                 cikis_gecerli_q;

  logic [127:0]         kaydirilmis;
  logic [127:0]         sbox_cikis;
  logic [127:0]         durum_son_d;
  logic [127:0]         durum_tur_d;

  function automatic logic [31:0] ters_sutun_karistir(input logic [31:0] s);
    logic [7:0] a0, a1, a2, a3;
    a0 = s[31:24];
    a1 = s[23:16];
    a2 = s[15:8];
    a3 = s[7:0];
    return {gf_carp_0e(a0) ^ gf_carp_0b(a1) ^ gf_carp_0d(a2) ^ gf_carp_09(a3),
            gf_carp_09(a0) ^ gf_carp_0e(a1) ^ gf_carp_0b(a2) ^ gf_carp_0d(a3),
            gf_carp_0d(a0) ^ gf_carp_09(a1) ^ gf_carp_0e(a2) ^ gf_carp_0b(a3),
            gf_carp_0b(a0) ^ gf_carp_0d(a1) ^ gf_carp_09(a2) ^ gf_carp_0e(a3)};
  endfunction

  assign kaydirilmis = ters_satir_kaydir(durum_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    ters_sbox u_ters_sbox (
      .giris_i (kaydirilmis[8*i +: 8]),
      .cikis_o (sbox_cikis[8*i +: 8])
    );
  end

  // The final round is the same datapath with InvMixColumns bypassed.
  assign durum_son_d = sbox_cikis ^ tur_anahtari;

  for (genvar c = 0; c < 4; c++) begin : g_sutun
    assign durum_tur_d[127-32*c -: 32] = ters_sutun_karistir(durum_son_d[127-32*c -: 32]);
  end

  always_comb begin
    anahtar_idx = '0;
    case (state_q)
      BOS:     anahtar_idx = RK_IDX_W'(NR);
      TUR:     anahtar_idx = RK_IDX_W'(sayac_q);
      default: anahtar_idx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOS;
      durum_q         <= '0;
      sayac_q         <= '0;
      giris_hazir_q   <= 1'b0;
      cikis_gecerli_q <= 1'b0;
    end else begin
      case (state_q)
        BOS: begin
          giris_hazir_q <= 1'b1;
          if (giris_gecerli && giris_hazir_q) begin
            durum_q       <= sifreli_matris ^ tur_anahtari;
            sayac_q       <= SAYAC_W'(NR - 1);
            giris_hazir_q <= 1'b0;
            state_q       <= TUR;
          end
        end
        TUR: begin
          durum_q <= durum_tur_d;
          sayac_q <= sayac_q - SAYAC_W'(1);
          if (sayac_q == SAYAC_W'(1)) state_q <= SON;
        end
        SON: begin
          durum_q         <= durum_son_d;
          cikis_gecerli_q <= 1'b1;
          state_q         <= CIKIS;
        end
        CIKIS: begin
          if (cikis_hazir) begin
            cikis_gecerli_q <= 1'b0;
            giris_hazir_q   <= 1'b1;
            state_q         <= BOS;
          end
        end
        default: state_q <= BOS;
      endcase
    end
  end

  assign giris_hazir     = giris_hazir_q;
  assign cikis_gecerli   = cikis_gecerli_q;
  assign cozulmus_matris = durum_q;

`ifdef AES_BLOK_SAYACI_EN
  logic [31:0] blok_sayisi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blok_sayisi_q <= '0;
    end else if (cikis_gecerli_q && cikis_hazir) begin
      blok_sayisi_q <= blok_sayisi_q + 32'd1;
    end
  end

  assign blok_sayisi = blok_sayisi_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_ters_tur_cekirdegi.sv
`default_nettype none
// tb_aes_ters_tur_cekirdegi: scoreboard bench for the AES-128 inverse-cipher core.
module tb_aes_ters_tur_cekirdegi;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         giris_gecerli;
  logic         giris_hazir;
  logic [127:0] sifreli_matris;
  logic [3:0]   anahtar_idx;
  logic [127:0] tur_anahtari;
  logic         cikis_gecerli;
  logic         cikis_hazir;
  logic [127:0] cozulmus_matris;
`ifdef AES_BLOK_SAYACI_EN
  logic [31:0]  blok_sayisi;
`endif

  aes_ters_tur_cekirdegi u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .giris_gecerli   (giris_gecerli),
    .giris_hazir     (giris_hazir),
    .sifreli_matris  (sifreli_matris),
    .anahtar_idx     (anahtar_idx),
    .tur_anahtari    (tur_anahtari),
    .cikis_gecerli   (cikis_gecerli),
    .cikis_hazir     (cikis_hazir),
    .cozulmus_matris (cozulmus_matris)
`ifdef AES_BLOK_SAYACI_EN
    ,
    .blok_sayisi     (blok_sayisi)
`endif
  );

  always #5 clk = ~clk;

  logic [127:0] rk_tab [16];
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] sb [$];
  int           toplam = 0;
  int           gecen  = 0;
  int           bp_mode = 0;
  bit           idx_kontrol_en = 1'b0;

  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;

  assign tur_anahtari = (anahtar_idx <= 4'd10) ? rk_tab[anahtar_idx] : '0;

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) gecen++;
    else $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      y = y >> 1;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic anahtar_genislet(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {fwd_tab[t[31:24]], fwd_tab[t[23:16]], fwd_tab[t[15:8]], fwd_tab[t[7:0]]} ^ {rcon, 24'h0};
        rcon = rcon[7] ? ((rcon << 1) ^ 8'h1b) : (rcon << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rk_tab[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = ct[127-8*k -: 8] ^ rk_tab[10][127-8*k -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*((c+rr)%4)+rr] = s[4*c+rr];
      for (int k = 0; k < 16; k++) s[k] = inv_tab[t[k]] ^ rk_tab[r][127-8*k -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // Output side: backpressure and scoreboard pop, sampled on the falling edge.
  always @(negedge clk) begin
    case (bp_mode)
      0:       cikis_hazir = 1'b1;
      1:       cikis_hazir = ($urandom_range(0, 3) != 0);
      default: cikis_hazir = 1'b0;
    endcase
    if (rst_n && cikis_gecerli && cikis_hazir) begin
      if (sb.size() == 0) kontrol("beklenmeyen_cikis", 128'(cikis_gecerli), 128'(0));
      else kontrol("duz_metin", cozulmus_matris, sb.pop_front());
    end
    if (idx_kontrol_en) kontrol("anahtar_idx_aralik", 128'(anahtar_idx <= 4'd10), 128'(1));
  end

  task automatic adim();
    @(negedge clk);
    #1;
  endtask

  task automatic blok_gonder(input logic [127:0] ct, input logic [127:0] key,
                             input bit model_kullan, input logic [127:0] sabit);
    int n;
    n = 0;
    while (!giris_hazir && n < 300) begin
      adim();
      n++;
    end
    if (!giris_hazir) kontrol("hazir_zaman_asimi", 128'(giris_hazir), 128'(1));
    anahtar_genislet(key);
    sifreli_matris = ct;
    giris_gecerli  = 1'b1;
    sb.push_back(model_kullan ? ref_decrypt(ct) : sabit);
    adim();
    giris_gecerli  = 1'b0;
    sifreli_matris = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic bosalt();
    int n;
    n = 0;
    while ((sb.size() != 0 || cikis_gecerli) && n < 500) begin
      adim();
      n++;
    end
    kontrol("bosalt_kalan", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv, s;
    bit         bulundu;
    int         n;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
    for (int j = 0; j < 16; j++) rk_tab[j] = '0;

    rst_n          = 1'b0;
    giris_gecerli  = 1'b0;
    sifreli_matris = '0;
    repeat (3) adim();
    kontrol("rst_giris_hazir", 128'(giris_hazir), 128'(0));
    kontrol("rst_cikis_gecerli", 128'(cikis_gecerli), 128'(0));
    kontrol("rst_cozulmus", cozulmus_matris, 128'(0));
    kontrol("rst_anahtar_idx", 128'(anahtar_idx), 128'(10));
`ifdef AES_BLOK_SAYACI_EN
    kontrol("rst_blok_sayisi", 128'(blok_sayisi), 128'(0));
`endif
    rst_n = 1'b1;
    adim();
    kontrol("bos_giris_hazir", 128'(giris_hazir), 128'(1));

    // FIPS-197 C.1: latency and key index sequence.
    bp_mode = 0;
    kontrol("c1_idx_bos", 128'(anahtar_idx), 128'(10));
    blok_gonder(C1_CT, C1_KEY, 1'b0, C1_PT);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) adim();
      kontrol("c1_anahtar_idx", 128'(anahtar_idx), 128'((k <= 8) ? (9 - k) : 0));
      kontrol("c1_gecikme", 128'(cikis_gecerli), 128'(k == 10));
    end
    bosalt();

    // FIPS-197 B with a 20-cycle output stall and an ignored input.
    bp_mode = 2;
    blok_gonder(B_CT, B_KEY, 1'b0, B_PT);
    n = 0;
    while (!cikis_gecerli && n < 20) begin
      adim();
      n++;
    end
    kontrol("b_cikis_gecerli", 128'(cikis_gecerli), 128'(1));
    for (int k = 0; k < 20; k++) begin
      giris_gecerli  = (k >= 5 && k < 10);
      sifreli_matris = {$urandom, $urandom, $urandom, $urandom};
      adim();
      kontrol("stall_cikis", cozulmus_matris, B_PT);
      kontrol("stall_giris_hazir", 128'(giris_hazir), 128'(0));
      kontrol("stall_gecerli", 128'(cikis_gecerli), 128'(1));
      kontrol("stall_idx", 128'(anahtar_idx), 128'(0));
    end
    giris_gecerli = 1'b0;
    bp_mode = 0;
    adim();
    adim();
    kontrol("stall_sonra_hazir", 128'(giris_hazir), 128'(1));
    kontrol("stall_sonra_gecerli", 128'(cikis_gecerli), 128'(0));
    repeat (12) adim();
    kontrol("yok_sayilan_giris", 128'(cikis_gecerli), 128'(0));
    kontrol("stall_kuyruk", 128'(sb.size()), 128'(0));

    // Reset in the middle of round 5.
    blok_gonder({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, '0);
    bulundu = 1'b0;
    for (int k = 0; k < 20 && !bulundu; k++) begin
      if (anahtar_idx == 4'd5) bulundu = 1'b1;
      else adim();
    end
    kontrol("tur5_bulundu", 128'(bulundu), 128'(1));
    rst_n = 1'b0;
    #1;
    kontrol("async_cikis_gecerli", 128'(cikis_gecerli), 128'(0));
    kontrol("async_anahtar_idx", 128'(anahtar_idx), 128'(10));
    kontrol("async_giris_hazir", 128'(giris_hazir), 128'(0));
    kontrol("async_cozulmus", cozulmus_matris, 128'(0));
`ifdef AES_BLOK_SAYACI_EN
    kontrol("async_blok_sayisi", 128'(blok_sayisi), 128'(0));
`endif
    sb.delete();
    repeat (2) adim();
    rst_n = 1'b1;
    repeat (2) adim();
    kontrol("rst_sonra_hazir", 128'(giris_hazir), 128'(1));
    kontrol("rst_sonra_idx", 128'(anahtar_idx), 128'(10));
    blok_gonder(C1_CT, C1_KEY, 1'b0, C1_PT);
    bosalt();

    // Random keys and blocks against the model, with random backpressure.
    bp_mode = 1;
    idx_kontrol_en = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      blok_gonder({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b1, '0);
    end
    bosalt();
    idx_kontrol_en = 1'b0;
    bp_mode = 0;
`ifdef AES_BLOK_SAYACI_EN
    adim();
    kontrol("blok_sayisi", 128'(blok_sayisi), 128'(1001));
`endif

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
`default_nettype wire
